// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of uart_rx_fifo: FIFO pop handshake, fill level and sticky error flags.
// master = consumer logic, slave = the receiver.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en;
    logic                          err_clear;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          parity_err;
    logic                          framing_err;
    logic                          overrun_err;

    modport master (
        output rd_en, err_clear,
        input  rd_data, rd_valid, fifo_count, parity_err, framing_err, overrun_err
    );

    modport slave (
        input  rd_en, err_clear,
        output rd_data, rd_valid, fifo_count, parity_err, framing_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, show-ahead receive FIFO,
// registered RTS flow control and sticky parity/framing/overrun flags.
module uart_rx_fifo #(
    parameter int CLK_HZ        = 12000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rx,
    output logic           rts_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = 4;
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t               state, state_nxt;
    logic                 rx_s1, rxs;
    logic [TW-1:0]        timer;
    logic                 tick;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, par_x, par_ok;
    logic                 load_half, load_full, shift_en, par_en;
    logic                 push_req, set_pe, set_fe, set_oe;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 full, empty, push, pop;
    logic                 parity_err_q, framing_err_q, overrun_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rxs, rx_s1} <= 2'b11;
        else          {rxs, rx_s1} <= {rx_s1, rx};
    end

    assign tick  = (timer == '0);
    assign par_x = (^shreg) ^ par_bit;
    assign par_ok = (PARITY == 0) ? 1'b1 : ((PARITY == 1) ? par_x : ~par_x);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push_req  = 1'b0;
        set_pe    = 1'b0;
        set_fe    = 1'b0;
        case (state)
            S_IDLE: if (!rxs) begin
                load_half = 1'b1;
                state_nxt = S_START;
            end
            S_START: if (tick) begin
                if (rxs) state_nxt = S_IDLE;
                else begin
                    load_full = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: if (tick) begin
                shift_en  = 1'b1;
                load_full = 1'b1;
                if (bit_cnt == LAST_BIT) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tick) begin
                par_en    = 1'b1;
                load_full = 1'b1;
                state_nxt = S_STOP;
            end
            // A low stop sample ends the frame at once; later stop bits are not sampled.
            S_STOP: if (tick) begin
                if (!rxs) begin
                    set_fe    = 1'b1;
                    state_nxt = S_BREAK;
                end else if (stop_cnt == LAST_STOP) begin
                    state_nxt = S_IDLE;
                    if (par_ok) push_req = 1'b1;
                    else        set_pe   = 1'b1;
                end else begin
                    load_full = 1'b1;
                end
            end
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            if (load_half)      timer <= HALF_LOAD;
            else if (load_full) timer <= FULL_LOAD;
            else if (!tick)     timer <= timer - 1'b1;
            if (load_half)     bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (load_half)                    stop_cnt <= 1'b0;
            else if (state == S_STOP && tick) stop_cnt <= ~stop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        if (par_en)   par_bit <= rxs;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign pop    = bus.rd_en & ~empty;
    assign push   = push_req & (~full | pop);
    assign set_oe = push_req & full & ~pop;
    assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (pop && !push) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    // rd_data is registered; a push into an empty FIFO bypasses the memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_data_q     <= '0;
            rts_n         <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0)
                rd_data_q <= (push && rd_ptr_nxt == wr_ptr) ? shreg : mem[rd_ptr_nxt];
            rts_n         <= (count >= CW'(RTS_THRESHOLD));
            parity_err_q  <= set_pe | (parity_err_q  & ~bus.err_clear);
            framing_err_q <= set_fe | (framing_err_q & ~bus.err_clear);
            overrun_err_q <= set_oe | (overrun_err_q & ~bus.err_clear);
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = ~empty;
    assign bus.fifo_count  = count;
    assign bus.parity_err  = parity_err_q;
    assign bus.framing_err = framing_err_q;
    assign bus.overrun_err = overrun_err_q;
endmodule
